// File: rtl/execute_stage_block.sv
// Execute stage of the 8-bit MIPS pipeline: ALU, iterative shift-add multiplier,
// and the EX/MEM output registers consumed by the data-memory stage.
module execute_stage_block #(
   parameter int WIDTH      = 8,
   parameter int MUL_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_id,
   input  logic [3:0]       alu_op_id,
   input  logic [WIDTH-1:0] op_a_id,
   input  logic [WIDTH-1:0] op_b_id,
   input  logic [WIDTH-1:0] store_data_id,
   input  logic             mem_rw_id,
   input  logic             mem_en_id,
   input  logic             mem_mux_sel_id,
   input  logic             flush_ex,
   output logic             stall_ex,
   output logic [WIDTH-1:0] ans_ex,
   output logic [WIDTH-1:0] DM_data,
   output logic             mem_rw_ex,
   output logic             mem_en_ex,
   output logic             mem_mux_sel_ex,
   output logic             valid_ex,
   output logic             zero_ex,
   output logic             carry_ex
);

   localparam int CW  = $clog2(MUL_CYCLES);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SLT   = 4'd7;
   localparam logic [3:0] OP_MUL   = 4'd8;
   localparam logic [3:0] OP_PASSB = 4'd9;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic [WIDTH-1:0] ans_q, ans_d;
   logic [WIDTH-1:0] dm_data_q, dm_data_d;
   logic             mem_rw_q, mem_rw_d;
   logic             mem_en_q, mem_en_d;
   logic             mem_mux_sel_q, mem_mux_sel_d;
   logic             valid_q, valid_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic [WIDTH-1:0] mul_prod;
   logic             is_mul;
   logic             last_iter;

   assign is_mul    = (alu_op_id == OP_MUL);
   assign last_iter = (state_q == BUSY) && (cnt_q == CW'(MUL_CYCLES - 1));
   assign mul_prod  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign stall_ex  = valid_id & is_mul & ~last_iter & ~flush_ex;

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (alu_op_id)
         OP_ADD:   {alu_carry, alu_res} = {1'b0, op_a_id} + {1'b0, op_b_id};
         OP_SUB: begin
            alu_res   = op_a_id - op_b_id;
            alu_carry = (op_a_id < op_b_id);
         end
         OP_AND:   alu_res = op_a_id & op_b_id;
         OP_OR:    alu_res = op_a_id | op_b_id;
         OP_XOR:   alu_res = op_a_id ^ op_b_id;
         OP_SLL:   alu_res = op_a_id << op_b_id[SHW-1:0];
         OP_SRL:   alu_res = op_a_id >> op_b_id[SHW-1:0];
         OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a_id) < $signed(op_b_id))};
         OP_PASSB: alu_res = op_b_id;
         default:  alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_id && is_mul) state_d = BUSY;
         BUSY:    if (last_iter) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_ex) state_d = IDLE;
   end

   // Default is a bubble: controls drop, result/store data/flags hold.
   always_comb begin
      cnt_d         = cnt_q;
      mcand_d       = mcand_q;
      mplier_d      = mplier_q;
      acc_d         = acc_q;
      ans_d         = ans_q;
      dm_data_d     = dm_data_q;
      zero_d        = zero_q;
      carry_d       = carry_q;
      valid_d       = 1'b0;
      mem_rw_d      = 1'b0;
      mem_en_d      = 1'b0;
      mem_mux_sel_d = 1'b0;
      if (flush_ex) begin
         cnt_d = '0;
      end else if (state_q == BUSY) begin
         if (last_iter) begin
            ans_d         = mul_prod;
            zero_d        = (mul_prod == '0);
            carry_d       = 1'b0;
            dm_data_d     = store_data_id;
            mem_rw_d      = mem_rw_id;
            mem_en_d      = mem_en_id;
            mem_mux_sel_d = mem_mux_sel_id;
            valid_d       = 1'b1;
            cnt_d         = '0;
         end else begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
         end
      end else if (valid_id) begin
         if (is_mul) begin
            mcand_d  = op_a_id;
            mplier_d = op_b_id;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            ans_d         = alu_res;
            zero_d        = (alu_res == '0);
            carry_d       = alu_carry;
            dm_data_d     = store_data_id;
            mem_rw_d      = mem_rw_id;
            mem_en_d      = mem_en_id;
            mem_mux_sel_d = mem_mux_sel_id;
            valid_d       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         mcand_q       <= '0;
         mplier_q      <= '0;
         acc_q         <= '0;
         ans_q         <= '0;
         dm_data_q     <= '0;
         mem_rw_q      <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_mux_sel_q <= 1'b0;
         valid_q       <= 1'b0;
         zero_q        <= 1'b0;
         carry_q       <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         mcand_q       <= mcand_d;
         mplier_q      <= mplier_d;
         acc_q         <= acc_d;
         ans_q         <= ans_d;
         dm_data_q     <= dm_data_d;
         mem_rw_q      <= mem_rw_d;
         mem_en_q      <= mem_en_d;
         mem_mux_sel_q <= mem_mux_sel_d;
         valid_q       <= valid_d;
         zero_q        <= zero_d;
         carry_q       <= carry_d;
      end
   end

   assign ans_ex         = ans_q;
   assign DM_data        = dm_data_q;
   assign mem_rw_ex      = mem_rw_q;
   assign mem_en_ex      = mem_en_q;
   assign mem_mux_sel_ex = mem_mux_sel_q;
   assign valid_ex       = valid_q;
   assign zero_ex        = zero_q;
   assign carry_ex       = carry_q;

endmodule

// File: tb/tb_execute_stage_block.sv
// Bench for execute_stage_block: instruction-level model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_execute_stage_block;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid_id = 1'b0;
   logic [3:0] alu_op_id = 4'd0;
   logic [7:0] op_a_id = 8'd0;
   logic [7:0] op_b_id = 8'd0;
   logic [7:0] store_data_id = 8'd0;
   logic       mem_rw_id = 1'b0;
   logic       mem_en_id = 1'b0;
   logic       mem_mux_sel_id = 1'b0;
   logic       flush_ex = 1'b0;
   logic       stall_ex;
   logic [7:0] ans_ex;
   logic [7:0] DM_data;
   logic       mem_rw_ex, mem_en_ex, mem_mux_sel_ex;
   logic       valid_ex, zero_ex, carry_ex;

   int n_vec = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   execute_stage_block #(.WIDTH(8), .MUL_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .valid_id(valid_id), .alu_op_id(alu_op_id),
      .op_a_id(op_a_id), .op_b_id(op_b_id), .store_data_id(store_data_id),
      .mem_rw_id(mem_rw_id), .mem_en_id(mem_en_id), .mem_mux_sel_id(mem_mux_sel_id),
      .flush_ex(flush_ex), .stall_ex(stall_ex), .ans_ex(ans_ex), .DM_data(DM_data),
      .mem_rw_ex(mem_rw_ex), .mem_en_ex(mem_en_ex), .mem_mux_sel_ex(mem_mux_sel_ex),
      .valid_ex(valid_ex), .zero_ex(zero_ex), .carry_ex(carry_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction-level reference: returns {carry, result}.
   function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
      int ia, ib, sa, sb, r;
      logic c;
      ia = a; ib = b; c = 1'b0;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      case (op)
         4'd0: begin r = ia + ib; c = (r > 255); end
         4'd1: begin r = ia - ib + 256; c = (ia < ib); end
         4'd2: r = ia & ib;
         4'd3: r = ia | ib;
         4'd4: r = ia ^ ib;
         4'd5: r = ia * (1 << (ib % 8));
         4'd6: r = ia / (1 << (ib % 8));
         4'd7: r = (sa < sb) ? 1 : 0;
         4'd8: r = ia * ib;
         4'd9: r = ib;
         default: r = 0;
      endcase
      return {c, r[7:0]};
   endfunction

   logic [7:0] m_ans, m_dm, m_a, m_b;
   logic       m_valid, m_rw, m_en, m_mux, m_zero, m_carry;
   int         m_left;

   task automatic m_bubble();
      m_valid = 1'b0; m_rw = 1'b0; m_en = 1'b0; m_mux = 1'b0;
   endtask

   task automatic m_load(input logic [7:0] res, input logic c);
      m_ans = res; m_zero = (res == 8'd0); m_carry = c; m_dm = store_data_id;
      m_rw = mem_rw_id; m_en = mem_en_id; m_mux = mem_mux_sel_id; m_valid = 1'b1;
   endtask

   always @(posedge reset) begin
      m_ans = 0; m_dm = 0; m_a = 0; m_b = 0; m_left = 0;
      m_valid = 0; m_rw = 0; m_en = 0; m_mux = 0; m_zero = 0; m_carry = 0;
   end

   // A MUL occupies 8 busy cycles after acceptance; the last one emits the product.
   always @(posedge clk) begin
      logic [8:0] r;
      if (!reset) begin
         if (flush_ex) begin
            m_bubble(); m_left = 0;
         end else if (m_left == 1) begin
            r = alu_model(4'd8, m_a, m_b);
            m_load(r[7:0], 1'b0); m_left = 0;
         end else if (m_left > 1) begin
            m_bubble(); m_left--;
         end else if (valid_id && alu_op_id == 4'd8) begin
            m_a = op_a_id; m_b = op_b_id; m_left = 8; m_bubble();
         end else if (valid_id) begin
            r = alu_model(alu_op_id, op_a_id, op_b_id);
            m_load(r[7:0], r[8]);
         end else begin
            m_bubble();
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("valid_ex", valid_ex, m_valid);
         chk("ans_ex", ans_ex, m_ans);
         chk("DM_data", DM_data, m_dm);
         chk("mem_rw_ex", mem_rw_ex, m_rw);
         chk("mem_en_ex", mem_en_ex, m_en);
         chk("mem_mux_sel_ex", mem_mux_sel_ex, m_mux);
         chk("zero_ex", zero_ex, m_zero);
         chk("carry_ex", carry_ex, m_carry);
         chk("stall_ex", stall_ex,
             valid_id && alu_op_id == 4'd8 && m_left != 1 && !flush_ex);
      end
   end

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] sd = 8'd0, input logic rw = 1'b0,
                        input logic en = 1'b0, input logic mux = 1'b0);
      valid_id = 1'b1; alu_op_id = op; op_a_id = a; op_b_id = b;
      store_data_id = sd; mem_rw_id = rw; mem_en_id = en; mem_mux_sel_id = mux;
      flush_ex = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   // Hold the current instruction until decode is released; bounded to 20 cycles.
   task automatic run_held(output int stalls);
      logic s;
      stalls = 0;
      for (int k = 0; k < 20; k++) begin
         #1; s = stall_ex;
         if (s) stalls++;
         @(posedge clk); #1;
         if (!s) break;
      end
      valid_id = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid_ex"}, valid_ex, 1'b0);
      chk({tag, ".ans_ex"}, ans_ex, 8'h00);
      chk({tag, ".DM_data"}, DM_data, 8'h00);
      chk({tag, ".mem_en_ex"}, mem_en_ex, 1'b0);
      chk({tag, ".mem_rw_ex"}, mem_rw_ex, 1'b0);
      chk({tag, ".carry_ex"}, carry_ex, 1'b0);
   endtask

   typedef struct { logic [3:0] op; logic [7:0] a; logic [7:0] b; } vec_t;
   vec_t sweep[12];

   initial begin
      int stalls;
      #1 reset = 1'b1;
      #1 checking = 1'b1;
      chk_all_zero("reset0");
      tick(); tick();
      reset = 1'b0;

      drive(4'd0, 8'hF0, 8'h20); tick();
      chk("add.ans", ans_ex, 8'h10); chk("add.carry", carry_ex, 1'b1);
      chk("add.zero", zero_ex, 1'b0); chk("add.valid", valid_ex, 1'b1);

      drive(4'd1, 8'h05, 8'h05); tick();
      chk("sub.ans", ans_ex, 8'h00); chk("sub.zero", zero_ex, 1'b1);
      chk("sub.carry", carry_ex, 1'b0);

      drive(4'd7, 8'h80, 8'h01); tick();
      chk("slt.ans", ans_ex, 8'h01);

      drive(4'd0, 8'h10, 8'h04, 8'hAB, 1'b1, 1'b1); tick();
      chk("st.ans", ans_ex, 8'h14); chk("st.dm", DM_data, 8'hAB);
      chk("st.en", mem_en_ex, 1'b1); chk("st.rw", mem_rw_ex, 1'b1);

      // Asynchronous reset mid-cycle while outputs are nonzero.
      valid_id = 1'b0;
      #2 reset = 1'b1;
      #1 chk_all_zero("reset_mid");
      tick(); reset = 1'b0;

      drive(4'd8, 8'h0D, 8'h0B, 8'h5A, 1'b1, 1'b1);
      run_held(stalls);
      chk("mul1.stall_cycles", stalls, 8);
      chk("mul1.ans", ans_ex, 8'h8F); chk("mul1.valid", valid_ex, 1'b1);
      chk("mul1.dm", DM_data, 8'h5A);

      drive(4'd8, 8'h20, 8'h10);
      run_held(stalls);
      chk("mul2.stall_cycles", stalls, 8);
      chk("mul2.ans", ans_ex, 8'h00); chk("mul2.zero", zero_ex, 1'b1);

      // Flush while the multiplier is at iteration 4.
      drive(4'd8, 8'h07, 8'h09);
      repeat (5) tick();
      flush_ex = 1'b1;
      #1 chk("flush.stall_masked", stall_ex, 1'b0);
      tick();
      flush_ex = 1'b0; valid_id = 1'b0;
      #1 chk("flush.valid", valid_ex, 1'b0); chk("flush.stall", stall_ex, 1'b0);
      tick();
      chk("flush.no_result", valid_ex, 1'b0);
      drive(4'd0, 8'h01, 8'h02); tick();
      chk("post_flush.ans", ans_ex, 8'h03); chk("post_flush.valid", valid_ex, 1'b1);

      // Reset in the final multiplier iteration: no product may appear.
      drive(4'd8, 8'h03, 8'h05);
      repeat (8) tick();
      chk("cnt7.stall", stall_ex, 1'b0);
      #1 reset = 1'b1;
      #1 chk_all_zero("reset_cnt7");
      tick(); reset = 1'b0; valid_id = 1'b0;
      tick();
      chk("reset_cnt7.no_result", valid_ex, 1'b0);
      chk("reset_cnt7.ans", ans_ex, 8'h00);

      // Bubbles between ADDs: controls drop, result holds.
      drive(4'd0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1); tick();
      chk("bub.ans1", ans_ex, 8'h02); chk("bub.en1", mem_en_ex, 1'b1);
      valid_id = 1'b0; tick();
      chk("bub.valid0", valid_ex, 1'b0); chk("bub.en0", mem_en_ex, 1'b0);
      chk("bub.hold", ans_ex, 8'h02);
      drive(4'd0, 8'h03, 8'h04, 8'h00, 1'b0, 1'b1, 1'b1); tick();
      chk("bub.ans2", ans_ex, 8'h07); chk("bub.mux", mem_mux_sel_ex, 1'b1);
      valid_id = 1'b0; tick();
      chk("bub.hold2", ans_ex, 8'h07); chk("bub.mux0", mem_mux_sel_ex, 1'b0);

      // Back-to-back sweep of the remaining operations.
      sweep = '{'{4'd2, 8'hF0, 8'h3C}, '{4'd3, 8'hF0, 8'h0F}, '{4'd4, 8'hFF, 8'hFF},
                '{4'd5, 8'h81, 8'h01}, '{4'd6, 8'h80, 8'h03}, '{4'd7, 8'h01, 8'h80},
                '{4'd7, 8'hFE, 8'hFF}, '{4'd9, 8'h00, 8'hC3}, '{4'd12, 8'h55, 8'h66},
                '{4'd1, 8'h03, 8'h05}, '{4'd0, 8'h80, 8'h80}, '{4'd5, 8'h01, 8'h0F}};
      for (int i = 0; i < 12; i++) begin
         drive(sweep[i].op, sweep[i].a, sweep[i].b, 8'(i));
         tick();
         if (i == 3) chk("sll.ans", ans_ex, 8'h02);
         if (i == 4) chk("srl.ans", ans_ex, 8'h10);
         if (i == 8) chk("op12.valid", valid_ex, 1'b1);
         if (i == 9) chk("sub_borrow.carry", carry_ex, 1'b1);
      end
      valid_id = 1'b0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
